// File: rtl/pmem_write_buffer.sv
// Posted write buffer sitting between the victim cache and physical memory.
// Evicted dirty lines are absorbed into a small circular FIFO and drained to
// pmem whenever the upstream port is quiet. Reads that hit a buffered line are
// answered locally; everything else is forwarded to pmem.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | arbitrate: upstream write > upstream read > background drain
// RESPOND | one-cycle mem_resp to the victim cache
// PREAD   | read miss forwarded to pmem, waiting for pmem_resp
// PWRITE  | head entry being written to pmem, waiting for pmem_resp
module pmem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [127:0] mem_wdata,
  output logic         mem_resp,
  output logic [127:0] mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic         buf_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RESPOND, PREAD, PWRITE} state_t;

  state_t             state_q, state_d;
  logic [DEPTH-1:0]   valid_q;
  logic [11:0]        tag_q  [DEPTH];
  logic [127:0]       data_q [DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;
  logic [127:0]       rdata_q;
  logic [15:0]        paddr_q;
  logic [127:0]       pwdata_q;

  logic [11:0]        req_tag;
  logic               hit;
  logic [PTR_W-1:0]   hit_idx;
  logic               full;

  logic               do_overwrite;
  logic               do_push;
  logic               do_rd_hit;
  logic               do_rd_miss;
  logic               start_drain;
  logic               pread_done;
  logic               drain_done;

  // Offset bits inside a line carry no meaning for a line-level buffer.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^mem_address[3:0];

  assign req_tag = mem_address[15:4];
  assign full    = (count_q == CNT_W'(DEPTH));

  // Associative tag lookup; coalescing keeps at most one entry per tag.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decision and per-cycle action strobes.
  always_comb begin
    state_d      = state_q;
    do_overwrite = 1'b0;
    do_push      = 1'b0;
    do_rd_hit    = 1'b0;
    do_rd_miss   = 1'b0;
    start_drain  = 1'b0;
    pread_done   = 1'b0;
    drain_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          if (hit) begin
            do_overwrite = 1'b1;
            state_d      = RESPOND;
          end else if (!full) begin
            do_push = 1'b1;
            state_d = RESPOND;
          end else begin
            // Make room first; the write is re-evaluated once the drain ends.
            start_drain = 1'b1;
            state_d     = PWRITE;
          end
        end else if (mem_read) begin
          if (hit) begin
            do_rd_hit = 1'b1;
            state_d   = RESPOND;
          end else begin
            do_rd_miss = 1'b1;
            state_d    = PREAD;
          end
        end else if (count_q != '0) begin
          start_drain = 1'b1;
          state_d     = PWRITE;
        end
      end
      RESPOND: state_d = IDLE;
      PREAD: begin
        if (pmem_resp) begin
          pread_done = 1'b1;
          state_d    = RESPOND;
        end
      end
      PWRITE: begin
        if (pmem_resp) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry storage and FIFO bookkeeping; only IDLE pushes/overwrites, only
  // a finished drain pops, so the drained entry is never touched mid-flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (do_overwrite) begin
        data_q[hit_idx] <= mem_wdata;
      end
      if (do_push) begin
        valid_q[tail_q] <= 1'b1;
        tag_q[tail_q]   <= req_tag;
        data_q[tail_q]  <= mem_wdata;
        tail_q          <= tail_q + PTR_W'(1);
        count_q         <= count_q + CNT_W'(1);
      end
      if (drain_done) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
        count_q         <= count_q - CNT_W'(1);
      end
    end
  end

  // Registered read data and pmem address/data, loaded when a request starts
  // so that nothing on the upstream port reaches pmem combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q  <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      if (do_rd_hit)  rdata_q <= data_q[hit_idx];
      if (pread_done) rdata_q <= pmem_rdata;
      if (do_rd_miss) paddr_q <= {req_tag, 4'b0000};
      if (start_drain) begin
        paddr_q  <= {tag_q[head_q], 4'b0000};
        pwdata_q <= data_q[head_q];
      end
    end
  end

  assign mem_resp     = (state_q == RESPOND);
  assign pmem_read    = (state_q == PREAD);
  assign pmem_write   = (state_q == PWRITE);
  assign mem_rdata    = rdata_q;
  assign pmem_address = paddr_q;
  assign pmem_wdata   = pwdata_q;
  assign buf_empty    = (count_q == '0);

endmodule

// File: tb/tb_pmem_write_buffer.sv
module tb_pmem_write_buffer;

  localparam int DEPTH = 4;

  logic         clk;
  logic         reset_n;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] mem_wdata;
  logic         mem_resp;
  logic [127:0] mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         buf_empty;

  logic resp_auto;
  logic resp_man;
  assign pmem_resp = resp_auto | resp_man;

  pmem_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_resp     (mem_resp),
    .mem_rdata    (mem_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .buf_empty    (buf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the buffer is an ordered list of distinct lines (oldest
  // first); pmem is a sparse memory with a recognisable default pattern.
  typedef struct {
    logic [11:0]  tag;
    logic [127:0] data;
  } line_t;

  line_t        mq[$];
  logic [127:0] pmem_mem [logic [11:0]];
  logic [15:0]  log_a[$];
  logic [127:0] log_d[$];

  int total;
  int bad;
  int preads;
  bit withhold;
  bit rand_lat;
  logic [15:0] cur_rd_line;

  function automatic logic [127:0] init_pat(logic [11:0] t);
    return {8{4'hA, t}};
  endfunction

  function automatic logic [127:0] pmem_val(logic [11:0] t);
    if (pmem_mem.exists(t)) return pmem_mem[t];
    return init_pat(t);
  endfunction

  function automatic int find_line(logic [11:0] t);
    for (int i = 0; i < mq.size(); i++) if (mq[i].tag == t) return i;
    return -1;
  endfunction

  function automatic logic [127:0] model_read(logic [11:0] t);
    int idx;
    idx = find_line(t);
    if (idx >= 0) return mq[idx].data;
    return pmem_val(t);
  endfunction

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void model_write(logic [11:0] t, logic [127:0] d);
    int idx;
    line_t ln;
    idx = find_line(t);
    if (idx >= 0) begin
      mq[idx].data = d;
    end else begin
      total++;
      if (mq.size() >= DEPTH) begin
        bad++;
        $display("FAIL model_room: got %0d lines expected fewer than %0d", mq.size(), DEPTH);
      end
      ln.tag  = t;
      ln.data = d;
      mq.push_back(ln);
    end
  endfunction

  // A drain must write out exactly the oldest line the model holds.
  function automatic void note_drain(logic [15:0] a, logic [127:0] d);
    total++;
    if (mq.size() == 0) begin
      bad++;
      $display("FAIL drain_unexpected: got addr %h expected no drain", a);
    end else begin
      if (a !== {mq[0].tag, 4'b0000} || d !== mq[0].data) begin
        bad++;
        $display("FAIL drain_head: got %h/%h expected %h/%h", a, d, {mq[0].tag, 4'b0000}, mq[0].data);
      end
      void'(mq.pop_front());
    end
    pmem_mem[a[15:4]] = d;
    log_a.push_back(a);
    log_d.push_back(d);
  endfunction

  task automatic responder();
    int  wait_cnt;
    bit  prev_resp;
    wait_cnt  = 0;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      total++;
      if (pmem_read && pmem_write) begin
        bad++;
        $display("FAIL rd_wr_excl: got both pmem_read and pmem_write expected at most one");
      end
      total++;
      if (prev_resp && mem_resp) begin
        bad++;
        $display("FAIL resp_pulse: got mem_resp for 2 cycles expected 1");
      end
      prev_resp = mem_resp;
      if (resp_auto) begin
        resp_auto = 1'b0;
      end else if (!withhold && reset_n && (pmem_read || pmem_write)) begin
        if (!rand_lat || wait_cnt == 0) begin
          if (pmem_write) begin
            note_drain(pmem_address, pmem_wdata);
          end else begin
            chk("pread_addr", 128'(pmem_address), 128'(cur_rd_line));
            pmem_rdata = pmem_val(pmem_address[15:4]);
            preads++;
          end
          resp_auto = 1'b1;
          wait_cnt  = $urandom_range(0, 3);
        end else begin
          wait_cnt--;
        end
      end
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(output int cyc, output bit ok);
    cyc = 0;
    @(negedge clk);
    while (!mem_resp && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    ok = mem_resp;
  endtask

  // Caller is just after a rising edge; the request is sampled at cycle 0.
  task automatic bus_write(input logic [15:0] a, input logic [127:0] d, output int lat);
    bit ok;
    mem_address = a;
    mem_wdata   = d;
    mem_write   = 1'b1;
    wait_resp(lat, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wr_timeout: got no mem_resp for %h expected one", a);
    end else begin
      model_write(a[15:4], d);
    end
    sync();
    mem_write = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output int lat, output logic [127:0] rd,
                          output int npr, output int ndr);
    bit ok;
    int pr0;
    int dr0;
    pr0         = preads;
    dr0         = log_a.size();
    cur_rd_line = {a[15:4], 4'b0000};
    mem_address = a;
    mem_read    = 1'b1;
    wait_resp(lat, ok);
    rd  = mem_rdata;
    npr = preads - pr0;
    ndr = log_a.size() - dr0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rd_timeout: got no mem_resp for %h expected one", a);
    end
    sync();
    mem_read = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    @(negedge clk);
    while (!(buf_empty && !pmem_write) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_to_empty", 128'(buf_empty), 128'(1));
    sync();
  endtask

  typedef struct {
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] data;
    int           lat;
    logic [127:0] rdata;
    int           npr;
  } vec_t;

  localparam logic [127:0] DA  = {4{32'hAAAA_0001}};
  localparam logic [127:0] DA2 = {4{32'hA2A2_0002}};
  localparam logic [127:0] DB  = {4{32'hBBBB_0003}};
  localparam logic [127:0] DC  = {4{32'hCCCC_0004}};
  localparam logic [127:0] DD  = {4{32'hDDDD_0005}};
  localparam logic [127:0] DE  = {4{32'hEEEE_0006}};

  initial begin
    vec_t         tbl[10];
    int           lat;
    int           npr;
    int           ndr;
    int           s;
    int           n;
    logic [127:0] rd;
    logic [11:0]  t;
    logic [15:0]  exp_a[$];

    tbl[0] = '{1'b1, 16'h1230, DA,  1, '0, 0};
    tbl[1] = '{1'b0, 16'h1238, '0,  1, DA, 0};
    tbl[2] = '{1'b1, 16'h4000, DA2, 1, '0, 0};
    tbl[3] = '{1'b1, 16'h4000, DB,  1, '0, 0};
    tbl[4] = '{1'b0, 16'h4004, '0,  1, DB, 0};
    tbl[5] = '{1'b0, 16'h2000, '0,  2, init_pat(12'h200), 1};
    tbl[6] = '{1'b1, 16'h0010, DC,  1, '0, 0};
    tbl[7] = '{1'b1, 16'h0020, DD,  1, '0, 0};
    tbl[8] = '{1'b1, 16'h0030, DE,  3, '0, 0};
    tbl[9] = '{1'b0, 16'h1230, '0,  2, DA, 1};

    total       = 0;
    bad         = 0;
    preads      = 0;
    withhold    = 1'b0;
    rand_lat    = 1'b0;
    cur_rd_line = '0;
    resp_auto   = 1'b0;
    resp_man    = 1'b0;
    pmem_rdata  = '0;
    mem_address = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = '0;
    reset_n     = 1'b0;

    fork
      responder();
    join_none

    // Reset values.
    @(negedge clk);
    chk("rst_mem_resp",  128'(mem_resp),     128'(0));
    chk("rst_pmem_read", 128'(pmem_read),    128'(0));
    chk("rst_pmem_write",128'(pmem_write),   128'(0));
    chk("rst_pmem_addr", 128'(pmem_address), 128'(0));
    chk("rst_pmem_wdata",pmem_wdata,         128'(0));
    chk("rst_mem_rdata", mem_rdata,          128'(0));
    chk("rst_buf_empty", 128'(buf_empty),    128'(1));
    reset_n = 1'b1;
    sync();

    // Deterministic table: back-to-back operations, pmem answers at once.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) begin
        bus_write(tbl[i].addr, tbl[i].data, lat);
        chk($sformatf("tbl%0d_wr_lat", i), 128'(lat), 128'(tbl[i].lat));
        chk($sformatf("tbl%0d_not_empty", i), 128'(buf_empty), 128'(0));
      end else begin
        bus_read(tbl[i].addr, lat, rd, npr, ndr);
        chk($sformatf("tbl%0d_rd_lat", i), 128'(lat), 128'(tbl[i].lat));
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
        chk($sformatf("tbl%0d_npread", i), 128'(npr), 128'(tbl[i].npr));
        chk($sformatf("tbl%0d_no_drain", i), 128'(ndr), 128'(0));
      end
    end
    wait_empty();
    chk("tbl_drain_count", 128'(log_a.size()), 128'(5));
    if (log_a.size() == 5) begin
      exp_a = '{16'h1230, 16'h4000, 16'h0010, 16'h0020, 16'h0030};
      for (int i = 0; i < 5; i++) chk($sformatf("tbl_drain%0d_addr", i), 128'(log_a[i]), 128'(exp_a[i]));
      chk("coalesced_wdata", log_d[1], DB);
    end

    // Full buffer stall: pmem held off, fifth write forces a drain.
    withhold = 1'b1;
    s = log_a.size();
    for (int i = 0; i < 4; i++) begin
      bus_write(16'(i * 16), {8{16'(16'hF000 + i)}}, lat);
      chk($sformatf("fill%0d_lat", i), 128'(lat), 128'(1));
    end
    mem_address = 16'h0040;
    mem_wdata   = {8{16'hF004}};
    mem_write   = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 5) begin
        chk($sformatf("stall_c%0d_pwrite", c), 128'(pmem_write), 128'(1));
        chk($sformatf("stall_c%0d_paddr", c), 128'(pmem_address), 128'(16'h0000));
        chk($sformatf("stall_c%0d_noresp", c), 128'(mem_resp), 128'(0));
      end
      if (c == 5) begin
        note_drain(pmem_address, pmem_wdata);
        resp_man = 1'b1;
      end
      if (c == 6) begin
        resp_man = 1'b0;
        chk("stall_c6_noresp", 128'(mem_resp), 128'(0));
        chk("stall_c6_pwrite", 128'(pmem_write), 128'(0));
      end
      if (c == 7) chk("stall_c7_resp", 128'(mem_resp), 128'(1));
    end
    model_write(12'h004, {8{16'hF004}});
    sync();
    mem_write = 1'b0;
    withhold  = 1'b0;
    wait_empty();
    chk("stall_drain_count", 128'(log_a.size() - s), 128'(5));
    if (log_a.size() == s + 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("stall_order%0d", i), 128'(log_a[s + i]), 128'(16'(i * 16)));
    end

    // Reset in the middle of a drain.
    withhold = 1'b1;
    bus_write(16'h5550, DE, lat);
    chk("pre_rst_lat", 128'(lat), 128'(1));
    n = 0;
    @(negedge clk);
    while (!pmem_write && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_pwrite", 128'(pmem_write), 128'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_mem_resp",  128'(mem_resp),     128'(0));
    chk("mid_rst_pread",     128'(pmem_read),    128'(0));
    chk("mid_rst_pwrite",    128'(pmem_write),   128'(0));
    chk("mid_rst_paddr",     128'(pmem_address), 128'(0));
    chk("mid_rst_pwdata",    pmem_wdata,         128'(0));
    chk("mid_rst_rdata",     mem_rdata,          128'(0));
    chk("mid_rst_buf_empty", 128'(buf_empty),    128'(1));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mq.delete();
    withhold = 1'b0;
    sync();
    bus_read(16'h1230, lat, rd, npr, ndr);
    chk("post_rst_npread", 128'(npr), 128'(1));
    chk("post_rst_rdata", rd, pmem_val(12'h123));

    // Six pushes with idle gaps so drains interleave and pointers wrap.
    rand_lat = 1'b1;
    s = log_a.size();
    for (int i = 0; i < 6; i++) begin
      bus_write({12'(12'h300 + i), 4'h0}, {4{32'(32'h3000_0000 + i)}}, lat);
      n = $urandom_range(0, 4);
      for (int g = 0; g < n; g++) sync();
    end
    wait_empty();
    chk("wrap_drain_count", 128'(log_a.size() - s), 128'(6));
    if (log_a.size() == s + 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("wrap_order%0d", i), 128'(log_a[s + i]), 128'({12'(12'h300 + i), 4'h0}));
    end

    // Randomised traffic over a small set of lines against the model.
    for (int k = 0; k < 250; k++) begin
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) sync();
      t = 12'(12'h100 + $urandom_range(0, 7));
      if ($urandom_range(0, 9) < 6) begin
        bus_write({t, 4'($urandom_range(0, 15))}, {$urandom, $urandom, $urandom, $urandom}, lat);
      end else begin
        bus_read({t, 4'($urandom_range(0, 15))}, lat, rd, npr, ndr);
        chk($sformatf("rand%0d_rdata", k), rd, model_read(t));
      end
    end
    wait_empty();
    chk("rand_model_empty", 128'(mq.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
